// File: rtl/serial_add_sequencer_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
// Holds the FSM state encoding and the default operand width.
package serial_add_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sequencer_fa.sv
// FullAdder: single-bit full adder cell shared by the serial datapath.
// Ports: a, b, c_in -> s (sum bit), c_out (carry out).
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: one FullAdder reused for WIDTH cycles, LSB first.
// Ports: clk, reset (sync, high), start/sub/a/b/c_in in; busy/done/sum/c_out/ovf out.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             c_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

  logic fa_s;
  logic fa_co;

  FullAdder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // New sum bit enters at the MSB; the oldest bit falls off the bottom.
  assign sum_sh_d = WIDTH'({fa_s, sum_sh_q} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= sub ? ~b : b;
            carry_q  <= sub ? 1'b1 : c_in;
            cnt_q    <= '0;
            sum_sh_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_sh_q <= sum_sh_d;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          carry_q  <= fa_co;
          // Carry into the MSB, kept for the overflow check.
          if (cnt_q == PRE) begin
            c_msb_q <= fa_co;
          end
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_sh_d;
            c_out_q <= fa_co;
            ovf_q   <= c_msb_q ^ fa_co;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=8).
// Table vectors, random ops vs arithmetic model, abort/reset sequences.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int checks;
  int failures;
  logic [W-1:0] prev_sum;
  logic         prev_co;
  logic         prev_ov;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Plain two's-complement arithmetic on the integer values.
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic icin,
                       output logic [W-1:0] os, output logic oco,
                       output logic oov);
    int unsigned bb;
    int unsigned ci;
    int unsigned t;
    int sa;
    int sb;
    int sr;
    bb = isub ? ((~ib) & ((1 << W) - 1)) : ib;
    ci = isub ? 1 : icin;
    t = ia + bb + ci;
    os = W'(t);
    oco = t[W];
    // Signed overflow: true result outside [-2^(W-1), 2^(W-1)-1].
    sa = ia[W-1] ? int'(ia) - (1 << W) : int'(ia);
    sb = ib[W-1] ? int'(ib) - (1 << W) : int'(ib);
    sr = isub ? sa - sb : sa + sb + int'(icin);
    oov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  // Entered and left at a negedge in IDLE, so successive calls
  // exercise back-to-back starts. glitch re-asserts start in RUN/DONE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic icin,
                        input logic [W-1:0] es, input logic eco,
                        input logic eov, input bit glitch);
    int lat;
    bit seen;
    a = ia;
    b = ib;
    sub = isub;
    c_in = icin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    c_in = 1'($urandom);
    seen = 0;
    lat = 1;
    while (!seen && lat <= W + 4) begin
      if (done) begin
        seen = 1;
      end else begin
        chk("busy_run", busy, 1);
        chk("held_sum", sum, prev_sum);
        chk("held_co", c_out, prev_co);
        chk("held_ov", ovf, prev_ov);
        if (glitch && lat == 3) begin
          a = 8'h11;
          b = 8'h22;
          sub = 1'b0;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, W + 1);
    chk("busy_done", busy, 0);
    chk("sum", sum, es);
    chk("c_out", c_out, eco);
    chk("ovf", ovf, eov);
    prev_sum = es;
    prev_co = eco;
    prev_ov = eov;
    if (glitch) begin
      a = 8'h33;
      b = 8'h44;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_hold", sum, es);
    if (glitch) begin
      for (int i = 0; i < W + 2; i++) begin
        @(negedge clk);
        chk("no_restart", busy, 0);
        chk("no_done2", done, 0);
      end
      chk("sum_single", sum, es);
    end
  endtask

  vec_t tbl[6];

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rsub;
    logic         rcin;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    bit           sawd;

    checks = 0;
    failures = 0;
    prev_sum = '0;
    prev_co = 1'b0;
    prev_ov = 1'b0;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", c_out, 0);
    chk("rst_ov", ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, back-to-back.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
             tbl[i].s, tbl[i].co, tbl[i].ov, 1'b0);
    end

    // Stray starts during RUN and DONE are dropped.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of RUN discards the operation.
    a = 8'h12;
    b = 8'h34;
    sub = 1'b0;
    c_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_co", c_out, 0);
    chk("abort_ov", ovf, 0);
    sawd = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (done) sawd = 1;
      @(negedge clk);
    end
    chk("abort_nodone", sawd, 0);
    prev_sum = '0;
    prev_co = 1'b0;
    prev_ov = 1'b0;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rsub = 1'($urandom);
      rcin = 1'($urandom);
      model(ra, rb, rsub, rcin, es, eco, eov);
      run_op(ra, rb, rsub, rcin, es, eco, eov, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
